// File: rtl/uart_tx_fifo_param.sv
// rtl/uart_tx_fifo_param.sv - parametrised UART transmitter fed by a small input FIFO
module uart_tx_fifo_param #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_s,
    input  logic                          rstn_s,
    input  logic                          iVALID,
    input  logic [DATA_W-1:0]             iDATA,
    input  logic [1:0]                    iPAR_MODE,
    input  logic                          iSTOP2,
    output logic                          oREADY,
    output logic                          oDATA,
    output logic                          oBUSY,
    output logic                          oFINISH,
    output logic [$clog2(FIFO_DEPTH):0]   oLEVEL
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              push;
    logic              pop;
    logic              fifo_nempty;
    logic [DATA_W-1:0] head;

    // Transmit FSM state
    state_t            state_q, state_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic [IW-1:0]     idx_q, idx_n;
    logic [DATA_W-1:0] shreg_q, shreg_n;
    logic              par_en_q;
    logic              par_bit_q;
    logic              stop2_q;
    logic              line_q, line_n;
    logic              bit_wrap;
    logic              frame_end;

    // Ready is derived from the registered level only, so a same-cycle pop never frees a slot
    assign oREADY      = (level_q != LW'(FIFO_DEPTH));
    assign push        = iVALID & oREADY;
    assign fifo_nempty = (level_q != '0);
    assign head        = mem[rd_ptr_q];
    assign bit_wrap    = (cnt_q == CW'(CLK_DIV - 1));
    assign oLEVEL      = level_q;
    assign oDATA       = line_q;

    // FIFO data array, written on every accepted push
    always_ff @(posedge clk_s) begin
        if (push) begin
            mem[wr_ptr_q] <= iDATA;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // FSM state register plus per-frame latched word and configuration
    always_ff @(posedge clk_s or negedge rstn_s) begin
        if (!rstn_s) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            line_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            shreg_q <= shreg_n;
            line_q  <= line_n;
            if (pop) begin
                par_en_q  <= (iPAR_MODE == 2'b01) || (iPAR_MODE == 2'b10);
                par_bit_q <= (iPAR_MODE == 2'b10) ? ~^head : ^head;
                stop2_q   <= iSTOP2;
            end
        end
    end

    // Next-state: bit timing, bit index, shift register and FIFO pop decisions
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        idx_n     = idx_q;
        shreg_n   = shreg_q;
        pop       = 1'b0;
        frame_end = 1'b0;
        if (state_q == S_IDLE) begin
            if (fifo_nempty) begin
                pop     = 1'b1;
                state_n = S_START;
                cnt_n   = '0;
                idx_n   = '0;
                shreg_n = head;
            end
        end else if (!bit_wrap) begin
            cnt_n = cnt_q + CW'(1);
        end else begin
            cnt_n = '0;
            case (state_q)
                S_START: begin
                    state_n = S_DATA;
                    idx_n   = '0;
                end
                S_DATA: begin
                    if (idx_q == IW'(DATA_W - 1)) begin
                        idx_n   = '0;
                        state_n = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_n   = idx_q + IW'(1);
                        shreg_n = shreg_q >> 1;
                    end
                end
                S_PARITY: begin
                    state_n = S_STOP;
                    idx_n   = '0;
                end
                S_STOP: begin
                    if (stop2_q && (idx_q == '0)) begin
                        idx_n = IW'(1);
                    end else begin
                        frame_end = 1'b1;
                        idx_n     = '0;
                        if (fifo_nempty) begin
                            pop     = 1'b1;
                            state_n = S_START;
                            shreg_n = head;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Outputs: next line level (registered above), busy and end-of-frame pulse
    always_comb begin
        line_n  = 1'b1;
        oBUSY   = (state_q != S_IDLE);
        oFINISH = frame_end;
        case (state_n)
            S_IDLE:   line_n = 1'b1;
            S_START:  line_n = 1'b0;
            S_DATA:   line_n = shreg_n[0];
            S_PARITY: line_n = par_bit_q;
            S_STOP:   line_n = 1'b1;
            default:  line_n = 1'b1;
        endcase
    end

endmodule
